// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit and its lane aligner.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_e;

  // True when the access cannot be issued: reserved size or an address
  // that is not naturally aligned for the access size.
  function automatic logic is_bad_access(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// External memory port: one req/ack transaction at a time.
// Latency: n/a (signal bundle only).
// Backpressure: master holds all request fields stable until bus_ack.
interface mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_write, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_write, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: byte enables, replicated store data, extracted load data.
// Latency: purely combinational.
// Backpressure: none; no state.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_shift;

  // Lane selection per access size; the load lane is shifted down then masked.
  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = wdata_i;
    rdata_shift = rdata_i >> {addr_lo_i, 3'b000};
    rdata_o     = rdata_shift;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rdata_shift[7:0]};
      end
      SIZE_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, rdata_shift[15:0]};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Runs one aligned load/store on the memory port per request; optional bus timeout via MEM_ACCESS_TIMEOUT_EN.
// Latency: accept at edge N, bus_req in N+1, done no earlier than N+2; misaligned/reserved errors at N+1.
// Backpressure: req_ready only in IDLE; requests outside IDLE are dropped, bus waits on bus_ack.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  output logic              req_ready,
  output logic [DATA_W-1:0] rdata_out,
  output logic              done,
  output logic              err,
  output logic              addr_update,
  mem_bus_if.master         bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  size_e             size_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              in_bus;
  logic              timeout;

  mem_lane_align u_lane_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.bus_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles spent in BUS; zero on every other state so entry starts clean.
  always_comb begin
    cnt_d   = (state_q == BUS) ? cnt_q + 1'b1 : '0;
    timeout = (state_q == BUS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  // Next-state: alignment is checked on the live request so a bad access
  // never reaches the bus; ack takes priority over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_bad_access(size_e'(req_size), addr_in[1:0])) state_d = ERR;
          else                                                 state_d = BUS;
        end
      end
      BUS: begin
        if (bus.bus_ack)  state_d = DONE;
        else if (timeout) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and load result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= SIZE_BYTE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
        write_q <= req_write;
        size_q  <= size_e'(req_size);
      end
      if (state_q == BUS && bus.bus_ack && !write_q) begin
        rdata_q <= lane_rdata;
      end
    end
  end

  // Status and bus drive decode; bus fields are forced to zero outside BUS.
  always_comb begin
    in_bus        = (state_q == BUS);
    req_ready     = (state_q == IDLE);
    done          = (state_q == DONE) || (state_q == ERR);
    err           = (state_q == ERR);
    addr_update   = (state_q == DONE);
    rdata_out     = rdata_q;
    bus.bus_req   = in_bus;
    bus.bus_write = in_bus & write_q;
    bus.bus_addr  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus.bus_wdata = in_bus ? lane_wdata : '0;
    bus.bus_be    = in_bus ? lane_be : 4'b0000;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned loads/stores, error cases, reset mid-transaction.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: bus_ack driven by the bench to model wait states.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_ready;
  logic [31:0] rdata_out;
  logic        done;
  logic        err;
  logic        addr_update;

  int checks = 0;
  int errors = 0;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_unit #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_ready   (req_ready),
    .rdata_out   (rdata_out),
    .done        (done),
    .err         (err),
    .addr_update (addr_update),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then withdraw it.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic wr, input logic [1:0] sz);
    addr_in   = a;
    wdata_in  = wd;
    req_write = wr;
    req_size  = sz;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    addr_in          = '0;
    wdata_in         = '0;
    req_valid        = 1'b0;
    req_write        = 1'b0;
    req_size         = 2'b00;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;

    // Reset state
    step();
    step();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_addr_update", {31'h0, addr_update}, 32'h0);
    check("rst_rdata", rdata_out, 32'h0);
    rst_n = 1'b1;
    step();

    // Word load at 0x100, three wait cycles
    issue(32'h0000_0100, 32'h0, 1'b0, 2'b10);
    check("wl_bus_req", {31'h0, bus_if.bus_req}, 32'h1);
    check("wl_bus_addr", bus_if.bus_addr, 32'h0000_0100);
    check("wl_bus_be", {28'h0, bus_if.bus_be}, 32'hF);
    check("wl_bus_write", {31'h0, bus_if.bus_write}, 32'h0);
    check("wl_req_ready", {31'h0, req_ready}, 32'h0);
    step();
    step();
    step();
    check("wl_wait_bus_req", {31'h0, bus_if.bus_req}, 32'h1);
    check("wl_wait_bus_addr", bus_if.bus_addr, 32'h0000_0100);
    check("wl_wait_done", {31'h0, done}, 32'h0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    check("wl_done", {31'h0, done}, 32'h1);
    check("wl_addr_update", {31'h0, addr_update}, 32'h1);
    check("wl_err", {31'h0, err}, 32'h0);
    check("wl_done_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("wl_rdata", rdata_out, 32'hDEAD_BEEF);
    step();
    check("wl_done_pulse_end", {31'h0, done}, 32'h0);
    check("wl_addr_update_end", {31'h0, addr_update}, 32'h0);
    check("wl_ready_again", {31'h0, req_ready}, 32'h1);

    // Byte store at 0x203, minimum latency ack
    issue(32'h0000_0203, 32'h0000_00A5, 1'b1, 2'b00);
    check("bs_bus_addr", bus_if.bus_addr, 32'h0000_0200);
    check("bs_bus_be", {28'h0, bus_if.bus_be}, 32'h8);
    check("bs_bus_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
    check("bs_bus_write", {31'h0, bus_if.bus_write}, 32'h1);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_if.bus_ack   = 1'b0;
    check("bs_done", {31'h0, done}, 32'h1);
    check("bs_rdata_kept", rdata_out, 32'hDEAD_BEEF);
    step();

    // Halfword load at 0x302
    issue(32'h0000_0302, 32'h0, 1'b0, 2'b01);
    check("hl_bus_addr", bus_if.bus_addr, 32'h0000_0300);
    check("hl_bus_be", {28'h0, bus_if.bus_be}, 32'hC);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1234_ABCD;
    step();
    bus_if.bus_ack   = 1'b0;
    check("hl_rdata", rdata_out, 32'h0000_1234);
    step();

    // Byte load at 0x101 picks lane 1
    issue(32'h0000_0101, 32'h0, 1'b0, 2'b00);
    check("bl_bus_be", {28'h0, bus_if.bus_be}, 32'h2);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1122_3344;
    step();
    bus_if.bus_ack   = 1'b0;
    check("bl_rdata", rdata_out, 32'h0000_0033);
    step();

    // Halfword store at 0x102
    issue(32'h0000_0102, 32'h0000_BEEF, 1'b1, 2'b01);
    check("hs_bus_be", {28'h0, bus_if.bus_be}, 32'hC);
    check("hs_bus_wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    step();

    // Misaligned word at 0x401
    issue(32'h0000_0401, 32'h0, 1'b0, 2'b10);
    check("mw_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check("mw_err", {31'h0, err}, 32'h1);
    check("mw_done", {31'h0, done}, 32'h1);
    check("mw_addr_update", {31'h0, addr_update}, 32'h0);
    check("mw_req_ready_busy", {31'h0, req_ready}, 32'h0);
    step();
    check("mw_req_ready_back", {31'h0, req_ready}, 32'h1);
    check("mw_err_end", {31'h0, err}, 32'h0);

    // Misaligned halfword and reserved size
    issue(32'h0000_0301, 32'h0, 1'b0, 2'b01);
    check("mh_err", {31'h0, err}, 32'h1);
    check("mh_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    step();
    issue(32'h0000_0000, 32'h0, 1'b1, 2'b11);
    check("rs_err", {31'h0, err}, 32'h1);
    step();
    check("rs_rdata_kept", rdata_out, 32'h0000_0033);

    // Reset while a load is on the bus
    issue(32'h0000_0500, 32'h0, 1'b0, 2'b10);
    check("rb_bus_req", {31'h0, bus_if.bus_req}, 32'h1);
    rst_n = 1'b0;
    step();
    check("rb_bus_req_drop", {31'h0, bus_if.bus_req}, 32'h0);
    check("rb_req_ready", {31'h0, req_ready}, 32'h1);
    check("rb_rdata", rdata_out, 32'h0);
    rst_n = 1'b1;
    step();

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Never acked: four BUS cycles then error
    issue(32'h0000_0600, 32'h0, 1'b0, 2'b10);
    step();
    step();
    step();
    check("to_cycle4_bus_req", {31'h0, bus_if.bus_req}, 32'h1);
    step();
    check("to_err", {31'h0, err}, 32'h1);
    check("to_done", {31'h0, done}, 32'h1);
    check("to_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    step();

    // Ack in the fourth BUS cycle wins over the timeout
    issue(32'h0000_0600, 32'h0, 1'b0, 2'b10);
    step();
    step();
    step();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_F00D;
    step();
    bus_if.bus_ack   = 1'b0;
    check("ta_err", {31'h0, err}, 32'h0);
    check("ta_done", {31'h0, done}, 32'h1);
    check("ta_rdata", rdata_out, 32'hCAFE_F00D);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
